// File: rtl/bcd_display_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_display_sequencer
//   Converts the multiplier's product into a sign flag plus BCD digits for the
//   seven-segment bank. Each start captures an operand and takes its magnitude.
//   A shift-and-add-3 (double dabble) loop then processes one bit per clock.
//   The registered display outputs update together in a single UPDATE cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        convert request, sampled only when idle
//   value        result to display (DATA_WIDTH bits)
//   signed_mode  1: value is two's complement, 0: unsigned
//   busy         high from LOAD through UPDATE
//   done         one-cycle pulse coincident with the output update
//   neg          show minus sign
//   digits       BCD digits, digit 0 (units) in bits [3:0]
//   blank        leading-zero blank mask, bit i blanks digit i
// ---------------------------------------------------------------------------
module bcd_display_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_UPDATE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DATA_WIDTH-1:0] r_op_val;
    logic                  r_op_sgn;
    logic [DATA_WIDTH:0]   r_mag;
    logic                  r_mag_nz;
    logic                  r_neg_pend;
    logic [BW-1:0]         r_bcd;
    logic [CW-1:0]         r_cnt;

    logic                  r_done;
    logic                  r_neg;
    logic [BW-1:0]         r_digits;
    logic [DIGITS-1:0]     r_blank;

    logic                  w_is_neg;
    logic [DATA_WIDTH:0]   w_op_ext;
    logic [DATA_WIDTH:0]   w_mag;
    logic [BW-1:0]         w_bcd_adj;
    logic [DIGITS-1:0]     w_blank;
    logic                  w_hi_zero;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_LOAD;
            S_LOAD:    w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_cnt == CW'(DATA_WIDTH - 1)) w_state_nxt = S_UPDATE;
            S_UPDATE:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- combinational helpers ----------------
    // Sign-extend to DATA_WIDTH+1 bits before negating so the most negative
    // input still yields a positive magnitude (16'h8000 -> 32768).
    always_comb begin
        w_is_neg = r_op_sgn & r_op_val[DATA_WIDTH-1];
        w_op_ext = {r_op_sgn & r_op_val[DATA_WIDTH-1], r_op_val};
        w_mag    = w_is_neg ? (~w_op_ext + 1'b1) : w_op_ext;
    end

    // Add-3 on every nibble that is 5 or more, ahead of the shift.
    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                  (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
        end
    end

    // A digit is blanked when it and every higher digit are zero; units
    // always shows.
    always_comb begin
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            w_hi_zero  = w_hi_zero & (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = w_hi_zero;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_val   <= '0;
            r_op_sgn   <= 1'b0;
            r_mag      <= '0;
            r_mag_nz   <= 1'b0;
            r_neg_pend <= 1'b0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_neg      <= 1'b0;
            r_digits   <= '0;
            r_blank    <= BLANK_RST;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_val <= value;
                        r_op_sgn <= signed_mode;
                    end
                end
                S_LOAD: begin
                    r_mag      <= w_mag;
                    r_mag_nz   <= |r_op_val;
                    r_neg_pend <= w_is_neg;
                    r_bcd      <= '0;
                    r_cnt      <= '0;
                end
                S_CONVERT: begin
                    r_bcd <= (w_bcd_adj << 1) | BW'(r_mag[DATA_WIDTH-1]);
                    r_mag <= r_mag << 1;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_UPDATE: begin
                    r_digits <= r_bcd;
                    r_neg    <= r_neg_pend & r_mag_nz;
                    r_blank  <= w_blank;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = r_done;
    assign neg    = r_neg;
    assign digits = r_digits;
    assign blank  = r_blank;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
module tb_bcd_display_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        signed_mode;
    logic        busy;
    logic        done;
    logic        neg;
    logic [19:0] digits;
    logic [4:0]  blank;

    int checks = 0;
    int errors = 0;

    bcd_display_sequencer #(.DATA_WIDTH(16), .DIGITS(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .value       (value),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .neg         (neg),
        .digits      (digits),
        .blank       (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        logic        sgn;
        logic        e_neg;
        logic [19:0] e_dig;
        logic [4:0]  e_blank;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge and sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for edge N, then watch until done. Checks latency, busy
    // profile and that the outputs do not move before the update.
    task automatic run_conv(input logic [15:0] v, input logic s, input string tag);
        logic [19:0] d0;
        logic [4:0]  b0;
        logic        n0;
        int          k;
        bit          busy_bad;
        bit          moved;
        d0 = digits; b0 = blank; n0 = neg;
        value = v; signed_mode = s; start = 1'b1;
        tick();
        start = 1'b0;
        value = ~v; signed_mode = ~s;
        busy_bad = (busy !== 1'b1);
        moved = 1'b0;
        k = 0;
        while (k < 40) begin
            tick();
            k++;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (digits !== d0 || blank !== b0 || neg !== n0) moved = 1'b1;
        end
        chk({tag, "_latency"}, k, 18);
        chk({tag, "_busy_during"}, {31'd0, busy_bad}, 0);
        chk({tag, "_stable"}, {31'd0, moved}, 0);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 0);
    endtask

    initial begin
        vecs[0]  = '{16'hFFFF, 1'b1, 1'b1, 20'h00001, 5'b11110};
        vecs[1]  = '{16'h8000, 1'b1, 1'b1, 20'h32768, 5'b00000};
        vecs[2]  = '{16'h8000, 1'b0, 1'b0, 20'h32768, 5'b00000};
        vecs[3]  = '{16'hFFFF, 1'b0, 1'b0, 20'h65535, 5'b00000};
        vecs[4]  = '{16'd1040, 1'b1, 1'b0, 20'h01040, 5'b10000};
        vecs[5]  = '{16'h0000, 1'b1, 1'b0, 20'h00000, 5'b11110};
        vecs[6]  = '{16'h0000, 1'b0, 1'b0, 20'h00000, 5'b11110};
        vecs[7]  = '{16'd9,    1'b0, 1'b0, 20'h00009, 5'b11110};
        vecs[8]  = '{16'h7FFF, 1'b1, 1'b0, 20'h32767, 5'b00000};
        vecs[9]  = '{16'd12345, 1'b0, 1'b0, 20'h12345, 5'b00000};
        vecs[10] = '{16'hD8F0, 1'b1, 1'b1, 20'h10000, 5'b00000};

        reset = 1'b1; start = 1'b0; value = '0; signed_mode = 1'b0;
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_busy",   {31'd0, busy}, 0);
        chk("rst_done",   {31'd0, done}, 0);
        chk("rst_neg",    {31'd0, neg}, 0);
        chk("rst_digits", {12'd0, digits}, 32'h00000);
        chk("rst_blank",  {27'd0, blank}, 32'b11110);

        // Table vectors, issued back to back (start at the edge after done).
        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].val, vecs[i].sgn, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_neg", i),    {31'd0, neg}, {31'd0, vecs[i].e_neg});
            chk($sformatf("vec%0d_digits", i), {12'd0, digits}, {12'd0, vecs[i].e_dig});
            chk($sformatf("vec%0d_blank", i),  {27'd0, blank}, {27'd0, vecs[i].e_blank});
        end
        tick();
        chk("done_one_cycle", {31'd0, done}, 0);

        // Extra starts at N+3 and N+10 must be ignored: one done at N+18.
        begin
            int ndone;
            int kdone;
            ndone = 0; kdone = -1;
            value = 16'h0000; signed_mode = 1'b1; start = 1'b1;
            tick();
            start = 1'b0;
            for (int k = 1; k <= 18; k++) begin
                if (k == 3 || k == 10) begin
                    value = 16'd5; signed_mode = 1'b0; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                tick();
                if (done === 1'b1) begin ndone++; kdone = k; end
            end
            start = 1'b0;
            chk("ign_done_count", ndone, 1);
            chk("ign_done_edge", kdone, 18);
            chk("ign_digits", {12'd0, digits}, 32'h00000);
            chk("ign_neg", {31'd0, neg}, 0);
        end
        // Next start at N+19, done at N+37.
        run_conv(16'd777, 1'b0, "b2b");
        chk("b2b_digits", {12'd0, digits}, 32'h00777);
        chk("b2b_blank",  {27'd0, blank}, 32'b11000);
        begin
            bit spurious;
            spurious = 1'b0;
            repeat (25) begin
                tick();
                if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            end
            chk("no_queued_start", {31'd0, spurious}, 0);
        end

        // Leave neg=1 and nonzero digits so the reset check is meaningful.
        run_conv(16'hFFFE, 1'b1, "pre_rst");
        chk("pre_rst_digits", {12'd0, digits}, 32'h00002);
        chk("pre_rst_neg",    {31'd0, neg}, 1);

        // Reset during conversion of 12345, start held with reset.
        value = 16'd12345; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        reset = 1'b1; start = 1'b1;
        #1;
        chk("mid_rst_busy",   {31'd0, busy}, 0);
        chk("mid_rst_neg",    {31'd0, neg}, 0);
        chk("mid_rst_digits", {12'd0, digits}, 32'h00000);
        chk("mid_rst_blank",  {27'd0, blank}, 32'b11110);
        tick();
        reset = 1'b0; start = 1'b0;
        begin
            bit spurious;
            spurious = 1'b0;
            repeat (25) begin
                tick();
                if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            end
            chk("mid_rst_no_done", {31'd0, spurious}, 0);
        end
        run_conv(16'd12345, 1'b0, "restart");
        chk("restart_digits", {12'd0, digits}, 32'h12345);
        chk("restart_neg",    {31'd0, neg}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
